fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, the width of the program counter and the redirect targets.
REQ-002 The block SHALL have parameter RESET_PC, default 0, the PC value loaded at reset.
REQ-003 The block SHALL have parameter PC_MAX, default 63, the last instruction-memory index before sequential wrap.
REQ-004 clk  in  1  clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  level; leaves IDLE when sampled high.
REQ-007 stall  in  1  hold the current PC (downstream back-pressure).
REQ-008 do_branch  in  1  taken-branch redirect request.
REQ-009 branch_target  in  ADDR_W  branch destination.
REQ-010 do_jump  in  1  jump redirect request.
REQ-011 jump_target  in  ADDR_W  jump destination.
REQ-012 halt_req  in  1  stop fetching permanently until reset.
REQ-013 pc  out  ADDR_W  registered PC driven to the fetch stage.
REQ-014 fetch_valid  out  1  current pc is a valid fetch this cycle.
REQ-015 redirect  out  1  high while in REDIRECT (bubble cycle).
REQ-016 halted  out  1  high in HALT.
REQ-017 redirect_count  out  8  count of accepted redirects.

Function
REQ-018 The state register SHALL hold IDLE, RUN, REDIRECT or HALT; pc, state and redirect_count SHALL be registered.
REQ-019 IDLE: pc held; fetch_valid=0; start=1 -> RUN next cycle; all other inputs ignored.
REQ-020 RUN and REDIRECT: per-cycle priority SHALL be halt_req > do_jump > do_branch > stall > increment.
REQ-021 halt_req=1 -> HALT next cycle; pc held.
REQ-022 do_jump=1 -> pc<=jump_target; state<=REDIRECT; if do_branch is also high, it SHALL be ignored.
REQ-023 do_branch=1 (do_jump=0) -> pc<=branch_target; state<=REDIRECT.
REQ-024 Redirect SHALL win over a simultaneous stall.
REQ-025 stall=1 with no redirect or halt -> pc and state held.
REQ-026 Otherwise in RUN, pc<=pc+1, or pc<=0 when pc==PC_MAX (wrap).
REQ-027 Redirect targets SHALL be loaded unmodified; the wrap rule applies only to increments.
REQ-028 REDIRECT lasts exactly 1 cycle, then RUN with pc unchanged, unless a new redirect or halt arrives.
REQ-029 A new redirect in REDIRECT SHALL reload pc, stay in REDIRECT for 1 more cycle, and count.
REQ-030 fetch_valid SHALL be combinational: 1 only when state==RUN and stall, do_branch, do_jump and halt_req are all 0.
REQ-031 redirect_count SHALL increment by 1 per accepted redirect and saturate at 255.
REQ-032 HALT: pc held; fetch_valid=0; halted=1; start and all requests ignored; exit only via rst.

Reset
REQ-033 rst=0 SHALL asynchronously force state=IDLE, pc=RESET_PC and redirect_count=0; fetch_valid, redirect and halted SHALL read 0.
REQ-034 Reset asserted mid-REDIRECT or in HALT SHALL discard the pending target and the halt, returning to IDLE.
REQ-035 After rst deasserts, the block SHALL stay in IDLE until start is sampled high.

Verification
REQ-036 Reset, start=1, 66 free-run cycles -> pc goes 0..63 then 0, 1; fetch_valid=1 each RUN cycle.
REQ-037 In RUN at pc=5, do_branch=1 with branch_target=20 -> next cycle pc=20, redirect=1, fetch_valid=0; following cycle RUN, pc=21 one cycle later; redirect_count=1.
REQ-038 do_jump=1 (jump_target=40), do_branch=1 (branch_target=10) and stall=1 in the same cycle -> pc=40, REDIRECT, count +1 only.
REQ-039 stall=1 for 3 cycles at pc=7 -> pc stays 7, fetch_valid=0; after release pc=8.
REQ-040 halt_req=1 together with do_jump -> HALT, pc unchanged, halted=1; later start/do_jump have no effect; rst=0 -> IDLE, pc=0.
REQ-041 300 back-to-back redirects -> redirect_count saturates at 255; rst asserted during REDIRECT -> pc=0 immediately, state IDLE.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction fetch PC sequencer: idle/run/redirect/halt control with a
// single-cycle redirect bubble and a saturating redirect counter.
module fetch_controller #(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned PC_MAX   = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic              do_branch,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              do_jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_valid,
  output logic              redirect,
  output logic              halted,
  output logic [7:0]        redirect_count
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StRun      = 2'd1;
  localparam logic [1:0] StRedirect = 2'd2;
  localparam logic [1:0] StHalt     = 2'd3;

  localparam logic [ADDR_W-1:0] PcReset = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PcLast  = ADDR_W'(PC_MAX);
  localparam logic [7:0]        CntMax  = 8'hFF;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              active;
  logic              take_halt;
  logic              take_jump;
  logic              take_branch;
  logic              take_redirect;
  logic              take_stall;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] pc_inc;

  // Request decode in priority order: halt > jump > branch > stall.
  always_comb begin
    active        = (state_q == StRun) || (state_q == StRedirect);
    take_halt     = active && halt_req;
    take_jump     = active && !halt_req && do_jump;
    take_branch   = active && !halt_req && !do_jump && do_branch;
    take_redirect = take_jump || take_branch;
    take_stall    = active && !halt_req && !do_jump && !do_branch && stall;
    redirect_pc   = take_jump ? jump_target : branch_target;
  end

  // Wrap applies only to sequential increments, never to redirect targets.
  always_comb begin
    if (pc_q == PcLast) begin
      pc_inc = '0;
    end else begin
      pc_inc = pc_q + ADDR_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
        end
      end
      StRun, StRedirect: begin
        if (take_halt) begin
          state_d = StHalt;
        end else if (take_redirect) begin
          state_d = StRedirect;
          pc_d    = redirect_pc;
        end else if (take_stall) begin
          state_d = state_q;
        end else if (state_q == StRun) begin
          pc_d = pc_inc;
        end else begin
          // Bubble done: resume at the redirect target without advancing.
          state_d = StRun;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (take_redirect && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      pc_q    <= PcReset;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc             = pc_q;
  assign fetch_valid    = (state_q == StRun) && !stall && !do_branch && !do_jump && !halt_req;
  assign redirect       = (state_q == StRedirect);
  assign halted         = (state_q == StHalt);
  assign redirect_count = cnt_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a per-cycle reference model comparison
// plus literal expectations at the interesting points of each scenario.
module tb_fetch_controller;

  localparam int AW = 9;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stall;
  logic          do_branch;
  logic [AW-1:0] branch_target;
  logic          do_jump;
  logic [AW-1:0] jump_target;
  logic          halt_req;
  logic [AW-1:0] pc;
  logic          fetch_valid;
  logic          redirect;
  logic          halted;
  logic [7:0]    redirect_count;

  fetch_controller #(
    .ADDR_W  (AW),
    .RESET_PC(0),
    .PC_MAX  (63)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stall         (stall),
    .do_branch     (do_branch),
    .branch_target (branch_target),
    .do_jump       (do_jump),
    .jump_target   (jump_target),
    .halt_req      (halt_req),
    .pc            (pc),
    .fetch_valid   (fetch_valid),
    .redirect      (redirect),
    .halted        (halted),
    .redirect_count(redirect_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: mode 0 idle, 1 run, 2 redirect bubble, 3 halted.
  int m_mode;
  int m_pc;
  int m_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode <= 0;
      m_pc   <= 0;
      m_cnt  <= 0;
    end else if (m_mode == 0) begin
      if (start) m_mode <= 1;
    end else if (m_mode == 1 || m_mode == 2) begin
      if (halt_req) begin
        m_mode <= 3;
      end else if (do_jump || do_branch) begin
        m_mode <= 2;
        m_pc   <= do_jump ? int'(jump_target) : int'(branch_target);
        m_cnt  <= (m_cnt < 255) ? m_cnt + 1 : 255;
      end else if (stall) begin
        m_mode <= m_mode;
      end else if (m_mode == 1) begin
        m_pc <= (m_pc == 63) ? 0 : m_pc + 1;
      end else begin
        m_mode <= 1;
      end
    end
  end

  int n_checks;
  int n_pass;
  int pcs[66];
  int fv_ones;

  task automatic lit(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic compare_model();
    int exp_fv;
    int got;
    int exp;
    exp_fv = (m_mode == 1 && !stall && !do_branch && !do_jump && !halt_req) ? 1 : 0;
    got = {int'(pc), int'(fetch_valid), int'(redirect), int'(halted), int'(redirect_count)} == 0
          ? 0 : 0;
    got = int'(pc) * 65536 + int'(redirect_count) * 8 + int'(fetch_valid) * 4
          + int'(redirect) * 2 + int'(halted);
    exp = m_pc * 65536 + m_cnt * 8 + exp_fv * 4 + ((m_mode == 2) ? 2 : 0)
          + ((m_mode == 3) ? 1 : 0);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL cycle_model @%0t: pc=%0d fv=%0d redir=%0d halt=%0d cnt=%0d, expected pc=%0d fv=%0d redir=%0d halt=%0d cnt=%0d",
               $time, pc, fetch_valid, redirect, halted, redirect_count, m_pc, exp_fv,
               (m_mode == 2), (m_mode == 3), m_cnt);
    end
  endtask

  // Compare against the model mid-cycle, then advance to just after the next edge.
  task automatic tick();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    start     = 1'b0;
    stall     = 1'b0;
    do_branch = 1'b0;
    do_jump   = 1'b0;
    halt_req  = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    fv_ones       = 0;
    rst           = 1'b1;
    branch_target = '0;
    jump_target   = '0;
    clear_req();
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    lit("reset_pc", int'(pc), 0);
    lit("reset_fv", int'(fetch_valid), 0);
    lit("reset_redirect", int'(redirect), 0);
    lit("reset_halted", int'(halted), 0);
    lit("reset_count", int'(redirect_count), 0);
    rst = 1'b1;

    // Idle ignores everything except start.
    do_jump = 1'b1; jump_target = 9'd50; stall = 1'b1;
    tick(); tick();
    lit("idle_pc_held", int'(pc), 0);
    lit("idle_count", int'(redirect_count), 0);
    clear_req();
    start = 1'b1;
    tick();
    start = 1'b0;

    // Free run with wrap at 63.
    for (int i = 0; i < 66; i++) begin
      pcs[i] = int'(pc);
      fv_ones += int'(fetch_valid);
      tick();
    end
    lit("run_pc0", pcs[0], 0);
    lit("run_pc63", pcs[63], 63);
    lit("run_wrap0", pcs[64], 0);
    lit("run_wrap1", pcs[65], 1);
    lit("run_fv_all", fv_ones, 66);

    // Branch at pc=5 to 20.
    tick(); tick(); tick();
    lit("pc_before_branch", int'(pc), 5);
    do_branch = 1'b1; branch_target = 9'd20;
    tick();
    clear_req();
    lit("branch_pc", int'(pc), 20);
    lit("branch_redirect", int'(redirect), 1);
    lit("branch_fv", int'(fetch_valid), 0);
    tick();
    lit("after_bubble_pc", int'(pc), 20);
    lit("after_bubble_fv", int'(fetch_valid), 1);
    tick();
    lit("branch_inc_pc", int'(pc), 21);
    lit("branch_count", int'(redirect_count), 1);

    // Jump beats branch and stall.
    do_jump = 1'b1; jump_target = 9'd40;
    do_branch = 1'b1; branch_target = 9'd10; stall = 1'b1;
    tick();
    clear_req();
    lit("jump_pc", int'(pc), 40);
    lit("jump_redirect", int'(redirect), 1);
    lit("jump_count", int'(redirect_count), 2);
    tick();

    // Stall at pc=7.
    do_jump = 1'b1; jump_target = 9'd7;
    tick();
    clear_req();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      lit("stall_pc", int'(pc), 7);
      lit("stall_fv", int'(fetch_valid), 0);
    end
    stall = 1'b0;
    tick();
    lit("stall_release_pc", int'(pc), 8);

    // Target beyond PC_MAX loads unmodified and increments without wrap.
    do_branch = 1'b1; branch_target = 9'd100;
    tick();
    clear_req();
    tick(); tick();
    lit("far_target_inc", int'(pc), 101);

    // Redirect while already in the bubble reloads and counts.
    do_jump = 1'b1; jump_target = 9'd62;
    tick();
    do_jump = 1'b0; do_branch = 1'b1; branch_target = 9'd63;
    tick();
    clear_req();
    lit("rr_pc", int'(pc), 63);
    lit("rr_redirect", int'(redirect), 1);
    lit("rr_count", int'(redirect_count), 6);
    tick(); tick();
    lit("rr_wrap", int'(pc), 0);
    tick();

    // Halt wins over jump; halt is sticky.
    halt_req = 1'b1; do_jump = 1'b1; jump_target = 9'd33;
    tick();
    clear_req();
    lit("halt_pc", int'(pc), 1);
    lit("halt_flag", int'(halted), 1);
    start = 1'b1; do_jump = 1'b1; do_branch = 1'b1;
    tick(); tick(); tick();
    lit("halt_sticky_pc", int'(pc), 1);
    lit("halt_sticky_count", int'(redirect_count), 6);
    clear_req();
    #3 rst = 1'b0;
    #1;
    lit("halt_rst_pc", int'(pc), 0);
    lit("halt_rst_halted", int'(halted), 0);
    lit("halt_rst_count", int'(redirect_count), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick(); tick();
    lit("post_rst_idle_fv", int'(fetch_valid), 0);

    // Saturation under back-to-back jumps, then reset mid-bubble.
    start = 1'b1;
    tick();
    start = 1'b0;
    do_jump = 1'b1;
    for (int i = 0; i < 300; i++) begin
      jump_target = AW'(i);
      tick();
    end
    clear_req();
    lit("sat_count", int'(redirect_count), 255);
    lit("sat_pc", int'(pc), 299);
    lit("sat_redirect", int'(redirect), 1);
    #3 rst = 1'b0;
    #1;
    lit("mid_redirect_rst_pc", int'(pc), 0);
    lit("mid_redirect_rst_redir", int'(redirect), 0);
    lit("mid_redirect_rst_count", int'(redirect_count), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
